// File: rtl/acoustic_pkg.sv
// Shared definitions for the acoustic offset path.
// Holds the UART framing constants, the transmitter state encoding, and
// small byte-level helpers (offset sign extension, packet checksum).
package acoustic_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         DATA_BITS      = 8;
    localparam int         BYTES_PER_PKT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Sign-extend an offset whose sign bit sits at position msb (0..7)
    // to a full byte. Bits above msb in val are ignored.
    function automatic logic [7:0] sext8(input logic [7:0] val, input int msb);
        logic [7:0] res;
        res = val;
        for (int i = 0; i < 8; i++) begin
            if (i > msb) begin
                res[i] = val[msb[2:0]];
            end else begin
                res[i] = val[i];
            end
        end
        return res;
    endfunction

    // Packet checksum: XOR of header and data bytes.
    function automatic logic [7:0] checksum8(input logic [7:0] hdr, input logic [7:0] data);
        return hdr ^ data;
    endfunction

endpackage

// File: rtl/offset_fifo.sv
// Small synchronous FIFO for queued offsets.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and data; accepted when not full, or when
//                  a pop happens in the same cycle
//   pop, dout      read request and first-word-fall-through head data
//   count          occupancy, held in its own counter (not derived from pointers)
//   full, empty    occupancy flags
module offset_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;
    logic             empty_s;

    // Occupancy flags and accepted push/pop; a pop frees the slot a full push needs.
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == COUNT_FULL);
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Pointers and occupancy counter; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/offset_uart_tx.sv
// Offset UART transmitter.
// Queues signed correlator offsets and sends each one as a 3-byte UART
// packet (header, sign-extended offset, XOR checksum), 8N1, LSB first.
// Ports:
//   AD9226_CLK    sample clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   offset_in     signed offset, OFFSET_MSB+1 bits
//   offset_valid  one-cycle strobe qualifying offset_in
//   tx            UART line, idle high
//   busy          packet in flight or offsets still queued
//   overflow      sticky, set when an offset is dropped on a full FIFO
//   fifo_count    current FIFO occupancy
module offset_uart_tx
    import acoustic_pkg::*;
#(
    parameter int         OFFSET_MSB   = 4,
    parameter int         CLKS_PER_BIT = 10,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic                        AD9226_CLK,
    input  logic                        reset_n,
    input  logic [OFFSET_MSB:0]         offset_in,
    input  logic                        offset_valid,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_PKT - 1);

    tx_state_t         state_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic [1:0]        byte_idx_r;
    logic [7:0]        shift_r;
    logic [7:0]        data_r;
    logic              tx_r;
    logic              busy_r;
    logic              overflow_r;

    logic [7:0]        push_din_s;
    logic [7:0]        fifo_dout_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              drop_s;
    logic              baud_last_s;
    logic              line_s;

    offset_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (AD9226_CLK),
        .rst_n (reset_n),
        .push  (offset_valid),
        .pop   (pop_s),
        .din   (push_din_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pop/drop decisions, sign extension of the incoming offset, bit-period end.
    always_comb begin
        push_din_s  = sext8(8'(offset_in), OFFSET_MSB);
        pop_s       = (state_r == IDLE) && !fifo_empty_s;
        drop_s      = offset_valid && fifo_full_s && !pop_s;
        baud_last_s = (baud_cnt_r == BAUD_LAST);
    end

    // Line level implied by the current state; registered into tx_r below.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            IDLE:    line_s = 1'b1;
            START:   line_s = 1'b0;
            DATA:    line_s = shift_r[bit_idx_r];
            STOP:    line_s = 1'b1;
            default: line_s = 1'b1;
        endcase
    end

    // Framing FSM with baud counter; the counter restarts on every bit or state change.
    always_ff @(posedge AD9226_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 2'd0;
            shift_r    <= 8'h00;
            data_r     <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= {BAUD_W{1'b0}};
                    bit_idx_r  <= 3'd0;
                    if (pop_s) begin
                        data_r     <= fifo_dout_s;
                        byte_idx_r <= 2'd0;
                        shift_r    <= HEADER;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        bit_idx_r  <= 3'd0;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        if (byte_idx_r == LAST_BYTE) begin
                            state_r <= IDLE;
                        end else if (byte_idx_r == 2'd0) begin
                            shift_r    <= data_r;
                            byte_idx_r <= 2'd1;
                            state_r    <= START;
                        end else begin
                            shift_r    <= checksum8(HEADER, data_r);
                            byte_idx_r <= 2'd2;
                            state_r    <= START;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs: line level, activity flag, sticky drop flag.
    always_ff @(posedge AD9226_CLK or negedge reset_n) begin
        if (!reset_n) begin
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            tx_r       <= line_s;
            busy_r     <= (state_r != IDLE) || (|fifo_count_s);
            overflow_r <= overflow_r || drop_s;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_offset_uart_tx.sv
// Self-checking bench for offset_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A timeline model predicts the line, busy, occupancy and overflow every
// cycle; a UART receiver decodes the line for literal byte checks.
module tb_offset_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int PKT   = 30 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] offset_in = 5'd0;
    logic       offset_valid = 1'b0;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    offset_uart_tx #(
        .OFFSET_MSB   (4),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .HEADER       (8'hA5)
    ) dut (
        .AD9226_CLK   (clk),
        .reset_n      (reset_n),
        .offset_in    (offset_in),
        .offset_valid (offset_valid),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    // ---------------- model ----------------
    int          cyc = 0;
    logic [7:0]  mq[$];
    int          m_idle_from = 0;
    int          m_p = -1000000;
    logic [29:0] m_bits = 30'h0;
    bit          m_ovf = 1'b0;
    int          last_strobe = 0;
    logic        exp_tx = 1'b1;
    logic        exp_busy = 1'b0;
    logic        exp_ovf = 1'b0;
    int          exp_cnt = 0;

    // Line bit sequence of a whole packet: per byte start, 8 data LSB first, stop.
    function automatic logic [29:0] pkt_bits(input logic [7:0] d);
        logic [7:0]  b [3];
        logic [29:0] r;
        b[0] = 8'hA5;
        b[1] = d;
        b[2] = 8'hA5 ^ d;
        r = 30'h0;
        for (int i = 0; i < 3; i++) begin
            r[i*10] = 1'b0;
            for (int k = 0; k < 8; k++) r[i*10+1+k] = b[i][k];
            r[i*10+9] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_idle_from = 0;
            m_p         = -1000000;
            m_ovf       = 1'b0;
            exp_tx      = 1'b1;
            exp_busy    = 1'b0;
            exp_ovf     = 1'b0;
            exp_cnt     = 0;
        end else begin
            int  prev_q;
            bit  pop;
            bit  active;
            cyc++;
            prev_q = mq.size();
            pop = (cyc >= m_idle_from) && (mq.size() != 0);
            if (pop) begin
                m_bits      = pkt_bits(mq.pop_front());
                m_p         = cyc;
                m_idle_from = cyc + PKT + 1;
            end
            if (offset_valid) begin
                last_strobe = cyc;
                if (mq.size() < DEPTH) mq.push_back(8'($signed(offset_in)));
                else m_ovf = 1'b1;
            end
            active   = (cyc >= m_p + 1) && (cyc <= m_p + PKT);
            exp_tx   = active ? m_bits[(cyc - m_p - 1) / CPB] : 1'b1;
            exp_busy = active || (prev_q != 0);
            exp_cnt  = mq.size();
            exp_ovf  = m_ovf;
        end
    end

    // ---------------- checking ----------------
    int         nvec = 0;
    int         nfail = 0;
    bit         dec_act = 1'b0;
    int         dec_i = 0;
    logic [7:0] dec_sh = 8'h00;
    logic       prev_tx = 1'b1;
    logic [7:0] dec_q[$];
    int         fall_q[$];
    int         rd_idx = 0;

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // One clock: compare against the model, then run the UART receiver.
    task automatic tick();
        int j;
        @(negedge clk);
        chk("tx", int'(tx), int'(exp_tx));
        chk("busy", int'(busy), int'(exp_busy));
        chk("fifo_count", int'(fifo_count), exp_cnt);
        chk("overflow", int'(overflow), int'(exp_ovf));
        if (!reset_n) begin
            dec_act = 1'b0;
            prev_tx = 1'b1;
        end else begin
            if (dec_act) begin
                dec_i++;
            end else if (prev_tx && !tx) begin
                dec_act = 1'b1;
                dec_i   = 0;
                fall_q.push_back(cyc);
            end
            if (dec_act && (dec_i % CPB) == CPB / 2) begin
                j = dec_i / CPB;
                if (j == 0) begin
                    chk("start_bit", int'(tx), 0);
                end else if (j <= 8) begin
                    dec_sh[j-1] = tx;
                end else begin
                    chk("stop_bit", int'(tx), 1);
                    dec_q.push_back(dec_sh);
                    dec_act = 1'b0;
                end
            end
            prev_tx = tx;
        end
    endtask

    task automatic strobe(input logic [4:0] v);
        offset_in    = v;
        offset_valid = 1'b1;
        tick();
        offset_valid = 1'b0;
    endtask

    task automatic wait_fall(input int budget);
        int k;
        int n;
        k = fall_q.size();
        n = 0;
        while (fall_q.size() == k && n < budget) begin
            tick();
            n++;
        end
        if (fall_q.size() == k) fail_now("wait_fall_timeout");
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((n < 3 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) fail_now("wait_idle_timeout");
    endtask

    task automatic expect_byte(input string name, input logic [7:0] req);
        if (rd_idx < dec_q.size()) begin
            chk(name, int'(dec_q[rd_idx]), int'(req));
            rd_idx++;
        end else begin
            fail_now({name, "_missing"});
        end
    endtask

    task automatic expect_pkt(input logic [7:0] v);
        expect_byte("pkt_header", 8'hA5);
        expect_byte("pkt_data", v);
        expect_byte("pkt_checksum", 8'hA5 ^ v);
    endtask

    initial begin
        int s;
        int k0;
        int n;

        // Reset state
        repeat (3) tick();
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_overflow", int'(overflow), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic packet, offset -3
        k0 = fall_q.size();
        strobe(-5'sd3);
        s = last_strobe;
        wait_fall(10);
        if (fall_q.size() > k0) begin
            chk("strobe_to_fall", fall_q[k0] - s, 2);
            n = 0;
            while (busy === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            chk("fall_to_busy_low", cyc - fall_q[k0], PKT);
        end
        expect_byte("neg3_header", 8'hA5);
        expect_byte("neg3_data", 8'hFD);
        expect_byte("neg3_checksum", 8'h58);
        repeat (2) tick();

        // Positive maximum
        strobe(5'd15);
        wait_idle(300);
        expect_byte("pos15_header", 8'hA5);
        expect_byte("pos15_data", 8'h0F);
        expect_byte("pos15_checksum", 8'hAA);

        // Push together with pop while full
        for (int v = 1; v <= 5; v++) strobe(5'(v));
        chk("full_count", int'(fifo_count), 4);
        n = 0;
        while (cyc + 1 < m_idle_from && n < 400) begin
            tick();
            n++;
        end
        strobe(5'd6);
        chk("push_pop_full_count", int'(fifo_count), 4);
        chk("push_pop_full_ovf", int'(overflow), 0);
        wait_idle(1000);
        chk("push_pop_ovf_after", int'(overflow), 0);
        for (int v = 1; v <= 6; v++) expect_pkt(8'(v));

        // Overflow: six back-to-back strobes
        k0 = fall_q.size();
        for (int v = 1; v <= 6; v++) strobe(5'(v));
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(fifo_count), 4);
        wait_idle(1000);
        chk("ovf_sticky", int'(overflow), 1);
        for (int v = 1; v <= 5; v++) expect_pkt(8'(v));
        chk("ovf_byte_falls", fall_q.size() - k0, 15);
        for (int i = 0; i < 4; i++) begin
            if (k0 + 3 * i + 3 < fall_q.size())
                chk("pkt_gap", fall_q[k0+3*i+3] - fall_q[k0+3*i], PKT + 1);
        end

        // Reset in the middle of the data byte
        strobe(5'd7);
        strobe(5'd2);
        wait_fall(10);
        repeat (57) tick();
        chk("pre_reset_tx", int'(tx), 0);
        chk("pre_reset_count", int'(fifo_count), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(tx), 1);
        chk("async_reset_count", int'(fifo_count), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_ovf", int'(overflow), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        rd_idx = dec_q.size();
        repeat (2) tick();
        strobe(5'b11111);
        wait_idle(300);
        expect_byte("neg1_header", 8'hA5);
        expect_byte("neg1_data", 8'hFF);
        expect_byte("neg1_checksum", 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
